// File: rtl/branch_resolve_unit.sv
// Resolves branch conditions, registers jump/mispredict (1-cycle latency, no backpressure: ex_valid=0 while stalled).
// Optional 2-bit predictor table when BRU_BHT_EN is defined; otherwise static not-taken prediction.
module branch_resolve_unit #(
   parameter int DATA_W    = 16,
   parameter int PC_W      = 16,
   parameter int BHT_DEPTH = 16,
   parameter int CNT_W     = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [PC_W-1:0]   fetch_pc,
   output logic              pred_taken,
   input  logic              ex_valid,
   input  logic [2:0]        ex_op,
   input  logic [DATA_W-1:0] ex_a,
   input  logic [DATA_W-1:0] ex_b,
   input  logic [PC_W-1:0]   ex_pc,
   input  logic              ex_pred,
   output logic              jump_en,
   output logic              mispredict,
   output logic [CNT_W-1:0]  mispredict_cnt
);

   localparam int IDX_W = $clog2(BHT_DEPTH);

   typedef enum logic [2:0] {
      OP_NOP    = 3'd0,
      OP_ALWAYS = 3'd1,
      OP_ZERO   = 3'd2,
      OP_NZERO  = 3'd3,
      OP_EQ     = 3'd4,
      OP_NE     = 3'd5,
      OP_LTS    = 3'd6,
      OP_LTU    = 3'd7
   } br_op_t;

   logic taken;
   logic resolve;
   logic mis_next;

   always_comb begin
      taken = 1'b0;
      case (br_op_t'(ex_op))
         OP_ALWAYS: taken = 1'b1;
         OP_ZERO:   taken = (ex_a == '0);
         OP_NZERO:  taken = (ex_a != '0);
         OP_EQ:     taken = (ex_a == ex_b);
         OP_NE:     taken = (ex_a != ex_b);
         OP_LTS:    taken = ($signed(ex_a) < $signed(ex_b));
         OP_LTU:    taken = (ex_a < ex_b);
         default:   taken = 1'b0;
      endcase
   end

   assign resolve = ex_valid && (ex_op != OP_NOP);

`ifdef BRU_BHT_EN
   logic [1:0]       bht [BHT_DEPTH];
   logic [IDX_W-1:0] fetch_idx;
   logic [IDX_W-1:0] ex_idx;
   logic             unused_pc_bits;

   assign fetch_idx      = fetch_pc[IDX_W-1:0];
   assign ex_idx         = ex_pc[IDX_W-1:0];
   assign unused_pc_bits = ^{fetch_pc[PC_W-1:IDX_W], ex_pc[PC_W-1:IDX_W]};
   // Table read is ahead of the write, so a same-index fetch sees the old counter.
   assign pred_taken     = bht[fetch_idx][1];
   assign mis_next       = taken != ex_pred;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < BHT_DEPTH; i++) bht[i] <= 2'b01;
      end else if (resolve) begin
         if (taken && bht[ex_idx] != 2'b11)
            bht[ex_idx] <= bht[ex_idx] + 2'b01;
         else if (!taken && bht[ex_idx] != 2'b00)
            bht[ex_idx] <= bht[ex_idx] - 2'b01;
      end
   end
`else
   logic unused_inputs;

   assign unused_inputs = ^{fetch_pc, ex_pc, ex_pred};
   // Static not-taken: every taken branch is a mispredict.
   assign pred_taken    = 1'b0;
   assign mis_next      = taken;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         jump_en        <= 1'b0;
         mispredict     <= 1'b0;
         mispredict_cnt <= '0;
      end else begin
         mispredict <= resolve && mis_next;
         if (resolve) jump_en <= taken;
         if (resolve && mis_next && (mispredict_cnt != {CNT_W{1'b1}}))
            mispredict_cnt <= mispredict_cnt + 1'b1;
      end
   end

endmodule

// File: doc/branch_resolve_unit.md
# branch_resolve_unit

Parametrised successor to the execute-stage jump-enable mux. It evaluates a wider set of branch conditions on two operands and registers the jump decision. It also detects mispredictions against the fetch-stage guess and maintains a small table of 2-bit saturating predictors that fetch reads each cycle. It sits between the ALU operand path and the PC select / pipeline flush logic.

## Interface
- DATA_W, 16, operand width
- PC_W, 16, PC width
- BHT_DEPTH, 16, predictor entries; power of 2, ≥2; IDX_W = log2(BHT_DEPTH)
- CNT_W, 16, mispredict counter width
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-low
- fetch_pc  in  PC_W  PC being fetched
- pred_taken  out  1  prediction for fetch_pc, combinational from table
- ex_valid  in  1  branch op present in execute this cycle
- ex_op  in  3  condition select
- ex_a  in  DATA_W  operand A (ALU A)
- ex_b  in  DATA_W  operand B
- ex_pc  in  PC_W  PC of the branch in execute
- ex_pred  in  1  prediction fetch made for this branch (piped down)
- jump_en  out  1  registered jump decision
- mispredict  out  1  registered one-cycle flush request
- mispredict_cnt  out  CNT_W  saturating mispredict count

## Operation
- ex_op encoding:
  - 000 NOP: hold jump_en
  - 001 ALWAYS: 1
  - 010 ZERO: ex_a==0
  - 011 NZERO: ex_a!=0
  - 100 EQ: ex_a==ex_b
  - 101 NE: ex_a!=ex_b
  - 110 LTS: signed ex_a<ex_b
  - 111 LTU: unsigned ex_a<ex_b
- Condition result `taken` is computed combinationally. All compares are full DATA_W; no extension.
- At a clk edge with ex_valid=1:
  - op≠NOP: jump_en←taken; mispredict←(taken≠ex_pred).
  - op=NOP: jump_en holds; mispredict←0; no table update.
- At a clk edge with ex_valid=0: jump_en holds; mispredict←0; no table update.
- Predictor table:
  - Index is pc[IDX_W-1:0]; same for fetch and update.
  - pred_taken = counter[idx(fetch_pc)][1].
  - Update on valid non-NOP ops only: increment if taken, else decrement; saturate at 0 and 3.
  - ALWAYS ops also update.
- mispredict_cnt increments on every edge that sets mispredict=1 and saturates at all-ones.

## Timing
- Resolve latency: 1 cycle. jump_en and mispredict are valid the cycle after ex_valid is sampled.
- mispredict is high for exactly one cycle per mispredicted branch. Back-to-back mispredicts give consecutive high cycles.
- Read-before-write: if fetch_pc and ex_pc map to the same index in one cycle, pred_taken shows the pre-update counter. The new value is visible the next cycle.
- Reset (async assert, any cycle including mid-update):
  - jump_en=0, mispredict=0, mispredict_cnt=0.
  - All counters=2'b01 (weakly not-taken), so pred_taken=0.
- Release is synchronous to clk by the top-level reset synchroniser. The first edge after release may resolve a branch.
- No stall input. The pipeline deasserts ex_valid while stalled.

## Configuration
- BRU_BHT_EN defined: predictor table present as above.
- BRU_BHT_EN undefined:
  - No table storage; pred_taken is constant 0 (static not-taken).
  - mispredict = taken on every valid non-NOP op.
  - fetch_pc is unused.
  - All other behaviour is unchanged.

## Test plan
- Reset: assert rst=0 mid-cycle with ex_valid=1, op=001 → jump_en=0, mispredict=0, mispredict_cnt=0 immediately; pred_taken=0 for fetch_pc=0..15.
- Conditions, DATA_W=16, ex_pred=0:
  - a=16'h8000, b=16'h0001, op=110 → jump_en=1.
  - Same operands, op=111 → jump_en=0.
  - a=0, op=010 → 1.
  - a=5, b=5, op=101 → 0.
- Hold: op=001 gives jump_en=1. Then op=000 valid, then ex_valid=0 for 3 cycles → jump_en stays 1 and mispredict stays 0 throughout.
- Training: ex_pc=4, op=001, ex_pred=0, 3 consecutive cycles:
  - mispredict=1,1,1; mispredict_cnt=3.
  - fetch_pc=4 shows pred_taken=0 then 1 (after first update, counter 01→10), staying 1 at saturation 11.
  - fetch_pc=20 (same index, BHT_DEPTH=16) also 1.
- Same-index collision: fetch_pc=ex_pc=7, counter 01, taken branch → pred_taken=0 that cycle, 1 next cycle.
- Counter saturation: CNT_W=4, 20 mispredicts → mispredict_cnt=4'hF.
- Build without BRU_BHT_EN: op=001 repeatedly → pred_taken always 0, mispredict=1 every resolve.
